// File: rtl/fp_accum_seq.sv
// fp_accum_seq
//   Sequential front end for a combinational IEEE-754 single-precision adder.
//   A run of `len` floats arrives on a valid/ready stream. Each accepted beat
//   is summed into the accumulator by presenting {acc, beat} to the adder and
//   capturing the adder's result on that same cycle. When the run completes,
//   the final sum is held on an output valid/ready handshake.
//
//   Optional feature macro: FP_ACC_SUB_EN
//     When defined, the block gains an in_sub input. A beat with in_sub=1 has
//     its sign flipped before it reaches the adder, so that beat is subtracted.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start, len        begin a run of len beats (sampled only in IDLE)
//   in_valid/ready    input beat handshake, in_data carries the float
//   in_sub            (FP_ACC_SUB_EN only) subtract this beat
//   add_a, add_b      operands to the external adder
//   add_result        sum returned by the adder in the same cycle
//   out_valid/ready   final-sum handshake, out_data is the accumulator
//   out_count         beats accumulated in the current run
//   busy              high whenever the block is not idle
//   flag_nan/flag_inf sticky per-run flags raised by captured adder results
module fp_accum_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
`ifdef FP_ACC_SUB_EN
  input  logic             in_sub,
`endif
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic             flag_nan,
  output logic             flag_inf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] remaining;
  logic             beat_fire;
  logic             res_exp_max;
  logic             res_mant_zero;

  assign add_a = acc;

  // The sign flip is applied unconditionally to the operand path; the flag is
  // only meaningful when in_valid is high, and results are only captured then.
`ifdef FP_ACC_SUB_EN
  assign add_b = {in_data[31] ^ in_sub, in_data[30:0]};
`else
  assign add_b = in_data;
`endif

  assign out_data  = acc;
  assign beat_fire = in_valid & in_ready;

  assign res_exp_max   = (add_result[30:23] == 8'hFF);
  assign res_mant_zero = (add_result[22:0] == 23'd0);

  // Single FSM register block. in_ready, out_valid and busy are registered
  // and updated together with the state transition they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= 32'h0;
      remaining <= '0;
      out_count <= '0;
      flag_nan  <= 1'b0;
      flag_inf  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= 32'h0;
            out_count <= '0;
            flag_nan  <= 1'b0;
            flag_inf  <= 1'b0;
            busy      <= 1'b1;
            if (len != '0) begin
              remaining <= len;
              in_ready  <= 1'b1;
              state     <= ACCUM;
            end else begin
              // Zero-length run: report +0 with no beats straight away.
              remaining <= '0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end

        ACCUM: begin
          if (beat_fire && remaining != '0) begin
            acc       <= add_result;
            remaining <= remaining - 1'b1;
            out_count <= out_count + 1'b1;
            flag_nan  <= flag_nan | (res_exp_max & ~res_mant_zero);
            flag_inf  <= flag_inf | (res_exp_max &  res_mant_zero);
            if (remaining == 1) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_seq.sv
// tb_fp_accum_seq
//   Directed bench for fp_accum_seq. The external adder is replaced by a
//   lookup of hand-computed single-precision sums for exactly the operand
//   pairs the scenarios produce; any other pair returns a poison value so a
//   wrong operand routing shows up as a wrong sum.
module tb_fp_accum_seq;

  localparam int CNT_W = 8;
  localparam logic [31:0] POISON = 32'hDEADBEEF;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sub;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             busy;
  logic             flag_nan;
  logic             flag_inf;

  int checks = 0;
  int fails  = 0;

  fp_accum_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef FP_ACC_SUB_EN
    .in_sub    (in_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_result(add_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy),
    .flag_nan  (flag_nan),
    .flag_inf  (flag_inf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed IEEE-754 sums for the operand pairs used below.
  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h00000000, 32'h3F800000}: return 32'h3F800000; // 0 + 1
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1 + 2
      {32'h40400000, 32'h40400000}: return 32'h40C00000; // 3 + 3
      {32'h3F800000, 32'h7FC00001}: return 32'h7FC00000; // 1 + NaN
      {32'h00000000, 32'h7F800000}: return 32'h7F800000; // 0 + Inf
      {32'h7F800000, 32'h3F800000}: return 32'h7F800000; // Inf + 1
      {32'h00000000, 32'h40A00000}: return 32'h40A00000; // 0 + 5
      {32'h40A00000, 32'hC0000000}: return 32'h40400000; // 5 + (-2)
      default:                      return POISON;
    endcase
  endfunction

  always_comb add_result = adder_model(add_a, add_b);

  // Issues start for one cycle; DUT is expected to be in IDLE.
  task automatic do_start(input logic [CNT_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents one beat and holds it until accepted, within a cycle budget.
  task automatic send_beat(input logic [31:0] d, input logic sub);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = sub;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (!in_ready) begin
      fails++;
      $display("[TB] FAIL beat_accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Completes the output handshake in one cycle.
  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %b required 0", in_ready); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    checks++; if (out_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_out_data: got %h required 00000000", out_data); end
    checks++; if (out_count !== 8'd0) begin fails++; $display("[TB] FAIL reset_out_count: got %0d required 0", out_count); end
    checks++; if ({flag_nan, flag_inf} !== 2'b00) begin fails++; $display("[TB] FAIL reset_flags: got %b required 00", {flag_nan, flag_inf}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_sum();
    do_start(8'd3);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("[TB] FAIL t1_accum_entry: in_ready=%b busy=%b required 1 1", in_ready, busy); end
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'h40000000, 1'b0);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL t1_early_valid: got %b required 0", out_valid); end
    checks++; if (out_data !== 32'h40400000) begin fails++; $display("[TB] FAIL t1_partial_acc: got %h required 40400000", out_data); end
    send_beat(32'h40400000, 1'b0);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL t1_out_valid: got %b required 1", out_valid); end
    checks++; if (out_data !== 32'h40C00000) begin fails++; $display("[TB] FAIL t1_sum: got %h required 40C00000", out_data); end
    checks++; if (out_count !== 8'd3) begin fails++; $display("[TB] FAIL t1_count: got %0d required 3", out_count); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL t1_hold_in_ready: got %b required 0", in_ready); end
    take_output();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL t1_release: out_valid=%b busy=%b required 0 0", out_valid, busy); end
  endtask

  // Starts immediately in the IDLE cycle after the previous handshake.
  task automatic test_back_to_back_zero_len();
    do_start(8'd0);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL t2_out_valid: got %b required 1", out_valid); end
    checks++; if (out_data !== 32'h0) begin fails++; $display("[TB] FAIL t2_data: got %h required 00000000", out_data); end
    checks++; if (out_count !== 8'd0) begin fails++; $display("[TB] FAIL t2_count: got %0d required 0", out_count); end
    checks++; if ({flag_nan, flag_inf} !== 2'b00) begin fails++; $display("[TB] FAIL t2_flags: got %b required 00", {flag_nan, flag_inf}); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL t2_in_ready: got %b required 0", in_ready); end
    take_output();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL t2_release: got %b required 0", out_valid); end
  endtask

  task automatic test_special_flags();
    do_start(8'd2);
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'h7FC00001, 1'b0);
    checks++; if (out_data !== 32'h7FC00000) begin fails++; $display("[TB] FAIL t3_nan_data: got %h required 7FC00000", out_data); end
    checks++; if ({flag_nan, flag_inf} !== 2'b10) begin fails++; $display("[TB] FAIL t3_nan_flags: got %b required 10", {flag_nan, flag_inf}); end
    take_output();
    do_start(8'd1);
    checks++; if (flag_nan !== 1'b0) begin fails++; $display("[TB] FAIL t3_nan_clear: got %b required 0", flag_nan); end
    send_beat(32'h3F800000, 1'b0);
    checks++; if (out_data !== 32'h3F800000) begin fails++; $display("[TB] FAIL t3_after_nan: got %h required 3F800000", out_data); end
    take_output();
    do_start(8'd2);
    send_beat(32'h7F800000, 1'b0);
    send_beat(32'h3F800000, 1'b0);
    checks++; if (out_data !== 32'h7F800000) begin fails++; $display("[TB] FAIL t3_inf_data: got %h required 7F800000", out_data); end
    checks++; if ({flag_nan, flag_inf} !== 2'b01) begin fails++; $display("[TB] FAIL t3_inf_flags: got %b required 01", {flag_nan, flag_inf}); end
    take_output();
  endtask

  task automatic test_gaps_and_backpressure();
    do_start(8'd2);
    send_beat(32'h3F800000, 1'b0);
    // Idle gap with a data value on the bus that must not be absorbed.
    in_data = 32'h40000000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_data !== 32'h3F800000 || out_count !== 8'd1) begin fails++; $display("[TB] FAIL t4_gap_hold[%0d]: data=%h count=%0d required 3F800000 1", i, out_data, out_count); end
    end
    send_beat(32'h40000000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h40400000) begin fails++; $display("[TB] FAIL t4_stall[%0d]: valid=%b data=%h required 1 40400000", i, out_valid, out_data); end
      @(posedge clk); #1;
    end
    take_output();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL t4_release: got %b required 0", out_valid); end
  endtask

  task automatic test_async_abort();
    do_start(8'd3);
    send_beat(32'h3F800000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("[TB] FAIL t5_abort_ctrl: valid=%b busy=%b ready=%b required 0 0 0", out_valid, busy, in_ready); end
    checks++; if (out_data !== 32'h0 || out_count !== 8'd0) begin fails++; $display("[TB] FAIL t5_abort_data: data=%h count=%0d required 00000000 0", out_data, out_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(8'd1);
    send_beat(32'h40A00000, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h40A00000) begin fails++; $display("[TB] FAIL t5_new_run: valid=%b data=%h required 1 40A00000", out_valid, out_data); end
    take_output();
  endtask

`ifdef FP_ACC_SUB_EN
  task automatic test_subtract();
    do_start(8'd2);
    send_beat(32'h40A00000, 1'b0);
    send_beat(32'h40000000, 1'b1);
    checks++; if (out_data !== 32'h40400000) begin fails++; $display("[TB] FAIL t6_sub: got %h required 40400000", out_data); end
    take_output();
  endtask
`endif

  initial begin
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    $display("[TB] starting fp_accum_seq bench");
    test_reset();
    test_basic_sum();
    test_back_to_back_zero_len();
    test_special_flags();
    test_gaps_and_backpressure();
    test_async_abort();
`ifdef FP_ACC_SUB_EN
    test_subtract();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
